// File: rtl/eq_lut_ctrl.sv
// Histogram-equalisation LUT builder: scans a CDF memory for its minimum nonzero entry, then
// divides each bin through an external divider and writes the saturated result into the LUT.
// Optional division watchdog is compiled in with `define EQ_DIV_TIMEOUT_EN.
module eq_lut_ctrl #(
  parameter int unsigned  BINS        = 256,
  parameter int unsigned  SIZE        = 307200,
  parameter int unsigned  DIV_TIMEOUT = 128,
  localparam int unsigned AW          = $clog2(BINS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          cdf_rd_en,
  output logic [AW-1:0] cdf_rd_addr,
  input  logic [31:0]   cdf_rd_data,
  output logic          div_en,
  output logic [31:0]   div_cdf_in,
  output logic [31:0]   div_cdf_min,
  input  logic [31:0]   div_g_out,
  input  logic          div_ready,
  output logic          lut_wr_en,
  output logic [AW-1:0] lut_wr_addr,
  output logic [7:0]    lut_wr_data,
  output logic [31:0]   cdf_min,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [3:0] {
    StIdle,
    StScanRd,
    StScanChk,
    StRd,
    StRdWait,
    StDivSetup,
    StDivRun,
    StWrite,
    StFin
  } state_e;

  state_e        state;
  logic [AW-1:0] idx;
  logic [31:0]   cdf;
  logic          last_bin;
  logic          rd_skip;
  logic          rd_sat;
  logic [7:0]    g_sat;

`ifdef EQ_DIV_TIMEOUT_EN
  localparam int unsigned TW = $clog2(DIV_TIMEOUT + 1);
  logic [TW-1:0] div_cnt;
`else
  assign error = 1'b0;
`endif

  assign last_bin    = (idx == AW'(BINS - 1));
  assign rd_skip     = (cdf_rd_data == '0) || (cdf_rd_data < cdf_min);
  // A minimum equal to the frame size leaves a zero divisor.
  assign rd_sat      = (cdf_min == 32'(SIZE));
  assign g_sat       = (div_g_out > 32'd255) ? 8'hff : div_g_out[7:0];
  assign div_cdf_in  = cdf;
  assign div_cdf_min = cdf_min;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      idx         <= '0;
      cdf         <= '0;
      cdf_min     <= '0;
      cdf_rd_en   <= 1'b0;
      cdf_rd_addr <= '0;
      div_en      <= 1'b0;
      lut_wr_en   <= 1'b0;
      lut_wr_addr <= '0;
      lut_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef EQ_DIV_TIMEOUT_EN
      error       <= 1'b0;
      div_cnt     <= '0;
`endif
    end else begin
      cdf_rd_en <= 1'b0;
      lut_wr_en <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            busy        <= 1'b1;
            cdf_min     <= '0;
            idx         <= '0;
            cdf_rd_en   <= 1'b1;
            cdf_rd_addr <= '0;
`ifdef EQ_DIV_TIMEOUT_EN
            error       <= 1'b0;
`endif
            state       <= StScanRd;
          end
        end
        StScanRd: state <= StScanChk;
        StScanChk: begin
          if (cdf_rd_data != '0 || last_bin) begin
            // An all-zero CDF leaves cdf_min at zero.
            cdf_min     <= cdf_rd_data;
            idx         <= '0;
            cdf_rd_en   <= 1'b1;
            cdf_rd_addr <= '0;
            state       <= StRd;
          end else begin
            idx         <= idx + 1'b1;
            cdf_rd_en   <= 1'b1;
            cdf_rd_addr <= idx + 1'b1;
            state       <= StScanRd;
          end
        end
        StRd: state <= StRdWait;
        StRdWait: begin
          cdf <= cdf_rd_data;
          if (rd_skip || rd_sat) begin
            lut_wr_en   <= 1'b1;
            lut_wr_addr <= idx;
            lut_wr_data <= rd_skip ? 8'h00 : 8'hff;
            state       <= StWrite;
          end else begin
            state <= StDivSetup;
          end
        end
        StDivSetup: begin
          div_en  <= 1'b1;
`ifdef EQ_DIV_TIMEOUT_EN
          div_cnt <= '0;
`endif
          state   <= StDivRun;
        end
        StDivRun: begin
          if (div_ready) begin
            div_en      <= 1'b0;
            lut_wr_en   <= 1'b1;
            lut_wr_addr <= idx;
            lut_wr_data <= g_sat;
            state       <= StWrite;
          end
`ifdef EQ_DIV_TIMEOUT_EN
          else if (div_cnt == TW'(DIV_TIMEOUT - 1)) begin
            div_en      <= 1'b0;
            error       <= 1'b1;
            lut_wr_en   <= 1'b1;
            lut_wr_addr <= idx;
            lut_wr_data <= 8'h00;
            state       <= StWrite;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
`endif
        end
        StWrite: begin
          if (last_bin) begin
            idx   <= '0;
            done  <= 1'b1;
            state <= StFin;
          end else begin
            idx         <= idx + 1'b1;
            cdf_rd_en   <= 1'b1;
            cdf_rd_addr <= idx + 1'b1;
            state       <= StRd;
          end
        end
        StFin: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_lut_ctrl.sv
// Randomised and directed bench for eq_lut_ctrl with a CDF memory model, a divider model and a
// per-bin reference LUT computed from the equalisation rules.
module tb_eq_lut_ctrl;
  localparam int unsigned BINS        = 256;
  localparam int unsigned SIZE        = 307200;
  localparam int unsigned DIV_TIMEOUT = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cdf_rd_en;
  logic [7:0]  cdf_rd_addr;
  logic [31:0] cdf_rd_data = '0;
  logic        div_en;
  logic [31:0] div_cdf_in;
  logic [31:0] div_cdf_min;
  logic [31:0] div_g_out = '0;
  logic        div_ready = 1'b0;
  logic        lut_wr_en;
  logic [7:0]  lut_wr_addr;
  logic [7:0]  lut_wr_data;
  logic [31:0] cdf_min;
  logic        busy;
  logic        done;
  logic        error;

  eq_lut_ctrl #(
    .BINS        (BINS),
    .SIZE        (SIZE),
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cdf_rd_en   (cdf_rd_en),
    .cdf_rd_addr (cdf_rd_addr),
    .cdf_rd_data (cdf_rd_data),
    .div_en      (div_en),
    .div_cdf_in  (div_cdf_in),
    .div_cdf_min (div_cdf_min),
    .div_g_out   (div_g_out),
    .div_ready   (div_ready),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data),
    .cdf_min     (cdf_min),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [BINS];
  bit          div_hang  = 1'b0;
  bit          div_force = 1'b0;
  bit          stray_en  = 1'b0;
  int          div_lat   = 1;
  int          div_cnt   = 0;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  exp_data [BINS];
  logic [31:0] exp_cmin;
  logic        exp_err;
  int          wr_idx, done_cnt, div_seen, run_len;

  function automatic longint unsigned model_div(logic [31:0] c, logic [31:0] m);
    longint unsigned num;
    num = (longint'(c) - longint'(m)) * 255;
    return num / (longint'(SIZE) - longint'(m));
  endfunction

  // CDF memory: data valid only in the cycle after the strobe, garbage otherwise.
  always @(posedge clk) cdf_rd_data <= cdf_rd_en ? mem[cdf_rd_addr] : 32'hdead_beef;

  always @(posedge clk) begin
    div_ready <= 1'b0;
    if (div_en && !div_ready) begin
      if (!div_hang && div_cnt + 1 >= div_lat) begin
        div_ready <= 1'b1;
        div_g_out <= div_force ? 32'd300 : 32'(model_div(div_cdf_in, div_cdf_min));
        div_cnt   <= 0;
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end else if (!div_en) begin
      div_cnt <= 0;
      if (stray_en && lut_wr_en && $urandom_range(0, 1) == 0) begin
        div_ready <= 1'b1;
        div_g_out <= 32'd77;
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void build_expect();
    longint unsigned q;
    logic [31:0] c;
    exp_cmin = '0;
    exp_err  = 1'b0;
    for (int i = 0; i < BINS; i++) begin
      if (mem[i] != 0) begin
        exp_cmin = mem[i];
        break;
      end
    end
    for (int i = 0; i < BINS; i++) begin
      c = mem[i];
      if (c == 0 || c < exp_cmin) exp_data[i] = 8'h00;
      else if (exp_cmin == SIZE) exp_data[i] = 8'hff;
      else if (div_hang) begin
        exp_data[i] = 8'h00;
        exp_err     = 1'b1;
      end else begin
        q = div_force ? 64'd300 : model_div(c, exp_cmin);
        exp_data[i] = (q > 255) ? 8'hff : q[7:0];
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    if (lut_wr_en) begin
      check($sformatf("wr_addr[%0d]", wr_idx), 64'(lut_wr_addr), 64'(wr_idx % 256));
      if (wr_idx < BINS)
        check($sformatf("wr_data[%0d]", wr_idx), 64'(lut_wr_data), 64'(exp_data[wr_idx]));
      check("wr_while_busy", 64'(busy), 64'd1);
      wr_idx++;
    end
    if (div_en) begin
      div_seen++;
      run_len++;
    end else begin
`ifdef EQ_DIV_TIMEOUT_EN
      if (div_hang && run_len != 0) check("timeout_len", 64'(run_len), 64'(DIV_TIMEOUT));
`endif
      run_len = 0;
    end
    if (div_en && div_ready && wr_idx < BINS) begin
      check($sformatf("div_in[%0d]", wr_idx), 64'(div_cdf_in), 64'(mem[wr_idx]));
      check("div_min", 64'(div_cdf_min), 64'(exp_cmin));
    end
    if (done) begin
      check("done_after_writes", 64'(wr_idx), 64'(BINS));
      check("cdf_min", 64'(cdf_min), 64'(exp_cmin));
      check("error_at_done", 64'(error), 64'(exp_err));
      done_cnt++;
    end
  endtask

  task automatic start_build();
    build_expect();
    div_lat  = int'($urandom_range(1, 4));
    wr_idx   = 0;
    done_cnt = 0;
    div_seen = 0;
    run_len  = 0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("error_cleared", 64'(error), 64'd0);
  endtask

  task automatic run_build(string tag, bit disturb);
    int budget;
    start_build();
    budget = 0;
    while (done_cnt == 0 && budget < 60000) begin
      if (disturb && busy && !done && $urandom_range(0, 30) == 0) start = 1'b1;
      tick();
      start = 1'b0;
      budget++;
    end
    if (done_cnt == 0) check({tag, "_done_seen"}, 64'd0, 64'd1);
    tick();
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_write_count"}, 64'(wr_idx), 64'(BINS));
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_zero_a"}, {cdf_rd_en, cdf_rd_addr, div_en, div_cdf_in, lut_wr_en, lut_wr_addr,
                             lut_wr_data, busy, done, error}, 64'd0);
    check({tag, "_zero_b"}, {div_cdf_min, cdf_min}, 64'd0);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < BINS; i++) mem[i] = 32'(1200 * (i + 1));
  endtask

  initial begin
    int budget;
    int v;
    fill_linear();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Linear CDF with a real divider.
    build_expect();
    check("model_cmin_lin", 64'(exp_cmin), 64'd1200);
    check("model_bin0_lin", 64'(exp_data[0]), 64'd0);
    check("model_bin127_lin", 64'(exp_data[127]), 64'd127);
    check("model_bin255_lin", 64'(exp_data[255]), 64'd255);
    run_build("linear", 1'b0);
    check("linear_cdf_min", 64'(cdf_min), 64'd1200);

    // Minimum equals frame size: divider bypassed.
    for (int i = 0; i < BINS; i++) mem[i] = (i < 10) ? 32'd0 : 32'(SIZE);
    build_expect();
    check("model_bin9_full", 64'(exp_data[9]), 64'd0);
    check("model_bin10_full", 64'(exp_data[10]), 64'd255);
    run_build("full", 1'b0);
    check("full_no_div", 64'(div_seen), 64'd0);
    check("full_cdf_min", 64'(cdf_min), 64'(SIZE));

    // Divider result above 255 saturates.
    fill_linear();
    div_force = 1'b1;
    build_expect();
    check("model_bin100_sat", 64'(exp_data[100]), 64'd255);
    run_build("sat", 1'b0);
    div_force = 1'b0;

    // Stray start and div_ready pulses must not disturb the sequence.
    stray_en = 1'b1;
    run_build("stray", 1'b1);
    stray_en = 1'b0;

    // Reset in the middle of bin 50's division.
    start_build();
    budget = 0;
    while (!(wr_idx == 50 && div_en) && budget < 20000) begin
      tick();
      budget++;
    end
    check("reached_bin50_div", 64'(wr_idx), 64'd50);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (4) begin
      tick();
      check("no_write_in_reset", 64'(lut_wr_en), 64'd0);
    end
    reset = 1'b1;
    tick();
    run_build("after_reset", 1'b0);

    // All-zero CDF.
    for (int i = 0; i < BINS; i++) mem[i] = 32'd0;
    build_expect();
    check("model_cmin_zero", 64'(exp_cmin), 64'd0);
    run_build("allzero", 1'b0);

    // Randomised CDFs: leading zeros, occasional entries below the minimum, overshoot past SIZE.
    repeat (3) begin
      int lead;
      lead = int'($urandom_range(0, 20));
      v = int'($urandom_range(2, 1000));
      for (int i = 0; i < BINS; i++) begin
        if (i < lead) mem[i] = 32'd0;
        else if (i > lead && $urandom_range(0, 15) == 0) mem[i] = $urandom_range(1, v - 1);
        else begin
          mem[i] = 32'(v);
          v = v + int'($urandom_range(0, 1800));
        end
      end
      stray_en = ($urandom_range(0, 1) == 1);
      run_build("random", 1'b1);
    end
    stray_en = 1'b0;

`ifdef EQ_DIV_TIMEOUT_EN
    // Divider never answers: watchdog writes 0 and flags error; next start clears it.
    for (int i = 0; i < BINS; i++) mem[i] = (i < 250) ? 32'd0 : 32'(1000 * (i - 249));
    div_hang = 1'b1;
    build_expect();
    check("model_err_hang", 64'(exp_err), 64'd1);
    run_build("timeout", 1'b0);
    check("timeout_error_sticky", 64'(error), 64'd1);
    div_hang = 1'b0;
    run_build("after_timeout", 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
